// File: rtl/pacman_pkg.sv
// pacman_pkg: maze geometry, scoring constants, cell codes and pellet tracker states
package pacman_pkg;
  localparam int GRID_W       = 28;
  localparam int GRID_H       = 31;
  localparam int N_CELLS      = GRID_W * GRID_H;
  localparam int TILE_SHIFT   = 3;
  localparam int MAZE_X0      = 204;
  localparam int MAZE_Y0      = 30;
  localparam int PELLET_PTS   = 10;
  localparam int POWER_PTS    = 50;
  localparam int POWER_FRAMES = 360;
  localparam logic [TILE_SHIFT-1:0] TILE_CTR = TILE_SHIFT'(1 << (TILE_SHIFT - 1));

  typedef enum logic [1:0] {CELL_NONE = 2'b00, CELL_PELLET = 2'b01, CELL_POWER = 2'b10} cell_t;
  typedef enum logic [1:0] {INIT, IDLE, RD, EAT} state_t;

  function automatic logic [9:0] cell_index(input logic [4:0] tx, input logic [4:0] ty);
    return 10'(ty) * 10'(GRID_W) + 10'(tx);
  endfunction
endpackage

// File: rtl/pellet_ram.sv
// pellet_ram: single-port pellet map, synchronous read, write-first
module pellet_ram #(
  parameter int DEPTH = 868,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [1:0]    wd,
  output logic [1:0]    rd
);
  logic [1:0] mem [DEPTH];
  // write-first port: a write returns the new data on the same cycle
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wd;
    rd <= we ? wd : mem[addr];
  end
endmodule

// File: rtl/pellet_tracker.sv
// pellet_tracker: per-tile pellet map, score, pellets-left and level-clear; PELLET_POWER_EN adds power pellets and power timer
module pellet_tracker
  import pacman_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        level_start,
  input  logic [9:0]  pm_xpos,
  input  logic [9:0]  pm_ypos,
  output logic [9:0]  rom_addr,
  input  logic [1:0]  rom_pellet,
  output logic        busy,
  output logic        eat_pulse,
  output logic [15:0] score,
  output logic [9:0]  pellets_left,
  output logic        level_clear,
  output logic        power_active
);
  state_t state, state_nx;
  logic pv, last_cell, accept, hit, is_power, ram_we;
  logic [9:0] pa, ca, ram_addr, idx;
  logic [1:0] rom_cell, ram_wd, ram_rd;
  logic [10:0] dx, dy;
  logic [15:0] pts;
  logic [16:0] sum;

  assign dx = {1'b0, pm_xpos} - 11'(MAZE_X0);
  assign dy = {1'b0, pm_ypos} - 11'(MAZE_Y0);
  assign accept = dx < 11'(GRID_W << TILE_SHIFT) && dy < 11'(GRID_H << TILE_SHIFT)
               && dx[TILE_SHIFT-1:0] == TILE_CTR && dy[TILE_SHIFT-1:0] == TILE_CTR;
  assign idx = cell_index(5'(dx >> TILE_SHIFT), 5'(dy >> TILE_SHIFT));
  assign last_cell = pv && pa == 10'(N_CELLS - 1);
  assign rom_cell = rom_pellet == 2'b11 ? CELL_NONE : rom_pellet;
  assign hit = ram_rd == CELL_PELLET || ram_rd == CELL_POWER;
`ifdef PELLET_POWER_EN
  assign is_power = ram_rd == CELL_POWER;
`else
  assign is_power = 1'b0;
`endif
  assign pts = is_power ? 16'(POWER_PTS) : 16'(PELLET_PTS);
  assign sum = {1'b0, score} + {1'b0, pts};

  pellet_ram #(.DEPTH(N_CELLS), .AW(10)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wd   (ram_wd),
    .rd   (ram_rd)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= INIT;
    else state <= state_nx;

  // next state and map port steering: INIT streams ROM into the map, EAT clears the looked-up cell
  always_comb begin
    state_nx = level_start ? INIT
             : state == INIT ? (last_cell ? IDLE : INIT)
             : state == IDLE ? (frame_tick && accept ? RD : IDLE)
             : state == RD ? EAT : IDLE;
    busy = state == INIT;
    ram_addr = busy ? pa : ca;
    ram_we = !level_start && (busy ? pv : state == EAT && hit);
    ram_wd = busy ? rom_cell : CELL_NONE;
  end

  // ROM walk, sample capture, scoring and pellet accounting
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rom_addr <= '0;
      pv <= 1'b0;
      pa <= '0;
      ca <= '0;
      score <= '0;
      pellets_left <= '0;
      eat_pulse <= 1'b0;
      level_clear <= 1'b0;
    end else begin
      eat_pulse <= 1'b0;
      if (level_start) begin
        rom_addr <= '0;
        pv <= 1'b0;
        pellets_left <= '0;
        level_clear <= 1'b0;
      end else if (state == INIT) begin
        pv <= !last_cell;
        pa <= rom_addr;
        rom_addr <= rom_addr == 10'(N_CELLS - 1) ? rom_addr : rom_addr + 10'd1;
        if (pv && rom_cell != CELL_NONE) pellets_left <= pellets_left + 10'd1;
      end else if (state == IDLE) begin
        if (frame_tick && accept) ca <= idx;
      end else if (state == EAT && hit) begin
        eat_pulse <= 1'b1;
        score <= sum[16] ? 16'hFFFF : sum[15:0];
        if (pellets_left != '0) pellets_left <= pellets_left - 10'd1;
        if (pellets_left == 10'd1) level_clear <= 1'b1;
      end
    end

`ifdef PELLET_POWER_EN
  logic [8:0] timer;
  // power timer: full reload on a power pellet, otherwise count frames down to zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) timer <= '0;
    else if (level_start) timer <= '0;
    else if (state == EAT && hit && is_power) timer <= 9'(POWER_FRAMES);
    else if (frame_tick && timer != '0) timer <= timer - 9'd1;
  assign power_active = timer != '0;
`else
  assign power_active = 1'b0;
`endif
endmodule

// File: tb/tb_pellet_tracker.sv
// tb_pellet_tracker: scoreboard bench for pellet_tracker; honours PELLET_POWER_EN
module tb_pellet_tracker;
`ifdef PELLET_POWER_EN
  localparam bit PWR = 1'b1;
`else
  localparam bit PWR = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, level_start = 1'b0;
  logic [9:0] pm_xpos = '0, pm_ypos = '0, rom_addr, pellets_left;
  logic [1:0] rom_pellet = '0;
  logic busy, eat_pulse, level_clear, power_active;
  logic [15:0] score;

  logic [1:0] rom_mem [0:1023];
  logic [1:0] mmap [0:867];
  int m_score = 0, m_left = 0, m_timer = 0;
  bit m_clear = 0;
  int vecs = 0, errs = 0;

  typedef struct {
    logic        eat;
    logic [15:0] score;
    logic [9:0]  left;
    logic        clear;
    logic        pwr;
  } exp_t;
  exp_t q[$];

  pellet_tracker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .level_start  (level_start),
    .pm_xpos      (pm_xpos),
    .pm_ypos      (pm_ypos),
    .rom_addr     (rom_addr),
    .rom_pellet   (rom_pellet),
    .busy         (busy),
    .eat_pulse    (eat_pulse),
    .score        (score),
    .pellets_left (pellets_left),
    .level_clear  (level_clear),
    .power_active (power_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_pellet <= rom_mem[rom_addr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic fill_rom(input logic [1:0] rest, input logic [1:0] c0, input logic [1:0] c439, input logic [1:0] c440);
    for (int i = 0; i < 1024; i++) rom_mem[i] = rest;
    rom_mem[0] = c0;
    rom_mem[439] = c439;
    rom_mem[440] = c440;
  endtask

  task automatic load_model();
    m_left = 0;
    m_clear = 0;
    m_timer = 0;
    for (int i = 0; i < 868; i++) begin
      mmap[i] = rom_mem[i] == 2'b11 ? 2'b00 : rom_mem[i];
      if (mmap[i] != 2'b00) m_left++;
    end
  endtask

  task automatic wait_init(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 2000);
  endtask

  task automatic check_init(input string tag);
    int n;
    wait_init(n);
    vecs++;
    if (n !== 869) begin
      errs++;
      $display("FAIL %s_busy_len got %0d cycles expected 869", tag, n);
    end
    vecs++;
    if (pellets_left !== 10'(m_left) || score !== 16'(m_score) || level_clear !== 1'b0) begin
      errs++;
      $display("FAIL %s_after_init pellets_left=%0d score=%0d level_clear=%b expected %0d %0d 0",
               tag, pellets_left, score, level_clear, m_left, m_score);
    end
  endtask

  // model one accepted/ignored sample and push the expected outcome
  task automatic model_sample(input int x, input int y);
    exp_t e;
    int dx, dy, idx;
    logic [1:0] c;
    dx = x - 204;
    dy = y - 30;
    e.eat = 1'b0;
    if (dx >= 0 && dx < 224 && dy >= 0 && dy < 248 && dx % 8 == 4 && dy % 8 == 4) begin
      idx = (dy / 8) * 28 + dx / 8;
      c = mmap[idx];
      if (c == 2'b01 || c == 2'b10) begin
        e.eat = 1'b1;
        mmap[idx] = 2'b00;
        m_score = m_score + ((PWR && c == 2'b10) ? 50 : 10);
        if (m_score > 65535) m_score = 65535;
        m_left--;
        if (m_left == 0) m_clear = 1;
        if (PWR && c == 2'b10) m_timer = 360;
      end
    end
    e.score = 16'(m_score);
    e.left = 10'(m_left);
    e.clear = m_clear;
    e.pwr = m_timer != 0;
    q.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    e = q.pop_front();
    vecs++;
    if (eat_pulse !== e.eat || score !== e.score || pellets_left !== e.left ||
        level_clear !== e.clear || power_active !== e.pwr) begin
      errs++;
      $display("FAIL %s got eat=%b score=%0d left=%0d clear=%b pwr=%b expected eat=%b score=%0d left=%0d clear=%b pwr=%b",
               tag, eat_pulse, score, pellets_left, level_clear, power_active,
               e.eat, e.score, e.left, e.clear, e.pwr);
    end
    @(posedge clk); #1;
    vecs++;
    if (eat_pulse !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL %s_after got eat=%b busy=%b expected 0 0", tag, eat_pulse, busy);
    end
  endtask

  task automatic tick(input int x, input int y, input string tag);
    pm_xpos = 10'(x);
    pm_ypos = 10'(y);
    if (m_timer > 0) m_timer--;
    model_sample(x, y);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    compare_out(tag);
  endtask

  task automatic restart(input bit with_tick, input string tag);
    pm_xpos = 10'd360;
    pm_ypos = 10'd154;
    level_start = 1'b1;
    frame_tick = with_tick;
    @(posedge clk); #1;
    level_start = 1'b0;
    frame_tick = 1'b0;
    load_model();
    vecs++;
    if (busy !== 1'b1 || rom_addr !== 10'd0 || level_clear !== 1'b0 || power_active !== 1'b0) begin
      errs++;
      $display("FAIL %s_entry busy=%b rom_addr=%0d clear=%b pwr=%b expected 1 0 0 0",
               tag, busy, rom_addr, level_clear, power_active);
    end
    check_init(tag);
  endtask

  task automatic test_reset();
    fill_rom(2'b01, 2'b00, 2'b01, 2'b01);
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    vecs++;
    if (busy !== 1'b1 || rom_addr !== 10'd0 || score !== 16'd0 || pellets_left !== 10'd0 ||
        eat_pulse !== 1'b0 || level_clear !== 1'b0 || power_active !== 1'b0) begin
      errs++;
      $display("FAIL reset_values busy=%b rom_addr=%0d score=%0d left=%0d eat=%b clear=%b pwr=%b expected 1 0 0 0 0 0 0",
               busy, rom_addr, score, pellets_left, eat_pulse, level_clear, power_active);
    end
    rst_n = 1'b1;
    m_score = 0;
    load_model();
    check_init("reset");
    vecs++;
    if (pellets_left !== 10'd867) begin
      errs++;
      $display("FAIL reset_pellets got %0d expected 867", pellets_left);
    end
  endtask

  task automatic test_eat();
    tick(360, 154, "eat_first");
    vecs++;
    if (score !== 16'd10 || pellets_left !== 10'd866) begin
      errs++;
      $display("FAIL eat_values score=%0d left=%0d expected 10 866", score, pellets_left);
    end
    tick(360, 154, "eat_repeat");
  endtask

  task automatic test_ignore();
    tick(361, 154, "ign_misaligned_x");
    tick(360, 155, "ign_misaligned_y");
    tick(100, 154, "ign_left_of_maze");
    tick(208, 20, "ign_above_maze");
    tick(432, 274, "ign_right_of_maze");
    tick(208, 34, "ign_empty_cell0");
    tick(424, 274, "edge_last_cell");
  endtask

  task automatic test_back_to_back();
    pm_xpos = 10'd360;
    pm_ypos = 10'd162;
    model_sample(360, 162);
    if (m_timer > 0) m_timer--;
    if (m_timer > 0) m_timer--;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    pm_xpos = 10'd368;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    @(posedge clk); #1;
    compare_out("b2b_first");
    tick(368, 162, "b2b_dropped_cell");
  endtask

  task automatic test_level_clear();
    fill_rom(2'b00, 2'b00, 2'b01, 2'b00);
    restart(1'b1, "lc_restart");
    tick(360, 154, "lc_last_pellet");
    vecs++;
    if (level_clear !== 1'b1 || pellets_left !== 10'd0) begin
      errs++;
      $display("FAIL lc_set clear=%b left=%0d expected 1 0", level_clear, pellets_left);
    end
    tick(360, 154, "lc_sticky");
    restart(1'b0, "lc_clear");
  endtask

  task automatic test_power();
    fill_rom(2'b00, 2'b00, 2'b10, 2'b01);
    restart(1'b0, "pw_restart");
    tick(360, 154, "pw_eat");
    for (int i = 1; i <= 360; i++) tick(100, 154, "pw_tick");
    vecs++;
    if (power_active !== 1'b0) begin
      errs++;
      $display("FAIL pw_expired got %b expected 0", power_active);
    end
  endtask

  task automatic test_init_abort();
    int n;
    level_start = 1'b1;
    @(posedge clk); #1;
    level_start = 1'b0;
    n = 0;
    while (rom_addr !== 10'd400 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    vecs++;
    if (rom_addr !== 10'd400) begin
      errs++;
      $display("FAIL abort_reach got rom_addr=%0d expected 400", rom_addr);
    end
    level_start = 1'b1;
    @(posedge clk); #1;
    level_start = 1'b0;
    vecs++;
    if (rom_addr !== 10'd0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL abort_restart rom_addr=%0d busy=%b expected 0 1", rom_addr, busy);
    end
    load_model();
    check_init("abort");
  endtask

  task automatic test_reset_mid_eat();
    pm_xpos = 10'd368;
    pm_ypos = 10'd154;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (busy !== 1'b1 || rom_addr !== 10'd0 || score !== 16'd0 || pellets_left !== 10'd0 ||
        eat_pulse !== 1'b0 || level_clear !== 1'b0 || power_active !== 1'b0) begin
      errs++;
      $display("FAIL rst_mid_eat busy=%b rom_addr=%0d score=%0d left=%0d eat=%b clear=%b pwr=%b expected 1 0 0 0 0 0 0",
               busy, rom_addr, score, pellets_left, eat_pulse, level_clear, power_active);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_score = 0;
    load_model();
    check_init("rst_mid_eat");
  endtask

  initial begin
    test_reset();
    test_eat();
    test_ignore();
    test_back_to_back();
    test_level_clear();
    test_power();
    test_init_abort();
    test_reset_mid_eat();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
